// File: rtl/wave_gen_pkg.sv
// Shared types and ROM-content helper for the wave_gen sample source; no timing or flow control.
package wave_gen_pkg;

  typedef logic signed [15:0] q15_t;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    SQUARE = 2'd1,
    TRI    = 2'd2,
    SAW    = 2'd3
  } wave_t;

  localparam q15_t Q15_MAX = 16'sd32767;
  localparam real  PI_HALF = 1.5707963267948966;

  // Gain is Q1.15 and non-negative; a set sign bit saturates to full scale.
  function automatic q15_t clamp_amp(logic [15:0] amp);
    return amp[15] ? Q15_MAX : q15_t'(amp);
  endfunction

  function automatic logic [14:0] sine_entry(int i, int n);
    real x;
    x = 32767.0 * $sin(PI_HALF * real'(i) / real'(n));
    return 15'($rtoi(x + 0.5));
  endfunction

endpackage

// File: rtl/wave_gen_sine_lut.sv
// Quarter-wave sine ROM, 2**LUT_AW x 15-bit unsigned, contents fixed at elaboration.
// Registered read: data appears the cycle after rd_en_i, then holds; no backpressure.
module wave_gen_sine_lut
  import wave_gen_pkg::*;
#(
  parameter int LUT_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [14:0]       dat_o
);

  localparam int N = 2 ** LUT_AW;

  logic [14:0] rom [N];
  logic [14:0] dat_q;

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom[g] = sine_entry(g, N);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q <= '0;
    end else if (rd_en_i) begin
      dat_q <= rom[addr_i];
    end
  end

  assign dat_o = dat_q;

endmodule

// File: rtl/wave_gen.sv
// DDS waveform source: one Q1.15 sample every CLK_DIV clocks, strobed 3 clocks after its tick.
// Free-running source with no backpressure; enable=0 freezes timing while in-flight samples drain.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [15:0]        amplitude,
  output logic               new_data,
  output logic [15:0]        x_out
);

  localparam int               CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               tick;

  always_comb begin
    tick    = enable && !phase_clr && (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (phase_clr) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      if (tick) begin
        phase_d = phase_q + phase_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // S1: shape generation from the pre-increment phase, plus ROM read.
  logic [15:0]       s_fld;
  logic [1:0]        quad;
  logic [13:0]       frac;
  logic [LUT_AW-1:0] fi;
  q15_t              tri_mag, raw_d;

  assign s_fld   = phase_q[PHASE_W-1 -: 16];
  assign quad    = s_fld[15:14];
  assign frac    = s_fld[13:0];
  assign fi      = frac[13 -: LUT_AW];
  assign tri_mag = q15_t'({1'b0, frac, 1'b0});

  always_comb begin
    raw_d = '0;
    unique case (wave_t'(wave_sel))
      SQUARE: raw_d = s_fld[15] ? -Q15_MAX : Q15_MAX;
      TRI: begin
        unique case (quad)
          2'd0:    raw_d = tri_mag;
          2'd1:    raw_d = Q15_MAX - tri_mag;
          2'd2:    raw_d = -tri_mag;
          default: raw_d = tri_mag - Q15_MAX;
        endcase
      end
      SAW:     raw_d = q15_t'(s_fld);
      default: raw_d = '0;
    endcase
  end

  logic [14:0] lut_dat;

  // Odd quadrants read the table mirrored so one quarter covers the whole cycle.
  wave_gen_sine_lut #(
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en_i (tick),
    .addr_i  (quad[0] ? ~fi : fi),
    .dat_o   (lut_dat)
  );

  logic  vld1_q, vld2_q, nd_q;
  wave_t sel1_q;
  q15_t  amp1_q, raw1_q;
  logic  neg1_q;
  q15_t  raw2;
  logic signed [31:0] prod_d, prod2_q;
  logic [15:0] x_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q <= 1'b0;
      sel1_q <= SINE;
      amp1_q <= '0;
      neg1_q <= 1'b0;
      raw1_q <= '0;
    end else begin
      vld1_q <= tick;
      if (tick) begin
        sel1_q <= wave_t'(wave_sel);
        amp1_q <= clamp_amp(amplitude);
        neg1_q <= quad[1];
        raw1_q <= raw_d;
      end
    end
  end

  // S2: final sine sign, then gain.
  always_comb begin
    raw2 = raw1_q;
    if (sel1_q == SINE) begin
      raw2 = neg1_q ? -q15_t'({1'b0, lut_dat}) : q15_t'({1'b0, lut_dat});
    end
    prod_d = 32'(raw2) * 32'(amp1_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld2_q  <= 1'b0;
      prod2_q <= '0;
      nd_q    <= 1'b0;
      x_q     <= '0;
    end else begin
      vld2_q <= vld1_q;
      if (vld1_q) begin
        prod2_q <= prod_d;
      end
      nd_q <= vld2_q;
      if (vld2_q) begin
        x_q <= 16'(prod2_q >>> 15);
      end
    end
  end

  assign new_data = nd_q;
  assign x_out    = x_q;

endmodule

// File: tb/tb_wave_gen.sv
// Randomised bench for wave_gen with a cycle-level behavioural reference and directed waveform tables.
module tb_wave_gen;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        phase_clr = 1'b0;
  logic [1:0]  wave_sel = 2'd0;
  logic [31:0] phase_inc = 32'd0;
  logic [15:0] amplitude = 16'd0;
  logic        new_data;
  logic [15:0] x_out;

  wave_gen #(
    .CLK_DIV (CLK_DIV),
    .PHASE_W (32),
    .LUT_AW  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .phase_clr (phase_clr),
    .wave_sel  (wave_sel),
    .phase_inc (phase_inc),
    .amplitude (amplitude),
    .new_data  (new_data),
    .x_out     (x_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int lut [256];

  typedef struct {
    longint due;
    int     val;
  } exp_t;

  exp_t        mq [$];
  longint      cyc = 0;
  int          m_cnt = 0;
  logic [31:0] m_phase = 32'd0;
  int          exp_x = 0;
  logic        exp_nd = 1'b0;
  longint      last_nd = -1;
  int          seen [$];
  longint      seen_cyc [$];

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Sample value straight from the waveform definitions, with floor division for the gain.
  function automatic int sample(logic [31:0] p, int sel, int amp);
    int s, q, f, a, raw, idx;
    s = int'(p[31:16]);
    q = s / 16384;
    f = s % 16384;
    a = (amp > 32767) ? 32767 : amp;
    case (sel)
      0: begin
        idx = f / 64;
        if (q % 2 == 1) idx = 255 - idx;
        raw = (q >= 2) ? -lut[idx] : lut[idx];
      end
      1: raw = (s < 32768) ? 32767 : -32767;
      2: begin
        case (q)
          0:       raw = 2 * f;
          1:       raw = 32767 - 2 * f;
          2:       raw = -2 * f;
          default: raw = -32767 + 2 * f;
        endcase
      end
      default: raw = (s >= 32768) ? s - 65536 : s;
    endcase
    return $rtoi($floor(real'(raw) * real'(a) / 32768.0));
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (phase_clr) begin
        m_cnt   = 0;
        m_phase = 32'd0;
      end else if (enable) begin
        if (m_cnt == CLK_DIV - 1) begin
          mq.push_back(exp_t'{cyc + 2, sample(m_phase, int'(wave_sel), int'(amplitude))});
          m_phase = m_phase + phase_inc;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    mq.delete();
    m_cnt   = 0;
    m_phase = 32'd0;
    exp_x   = 0;
    last_nd = -1;
  end

  always @(negedge clk) begin
    exp_nd = 1'b0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      exp_nd = 1'b1;
      exp_x  = mq[0].val;
      void'(mq.pop_front());
    end
    chk("new_data", int'(new_data), int'(exp_nd));
    chk("x_out", int'($signed(x_out)), exp_x);
    if (new_data) begin
      if (last_nd >= 0) chk("strobe_gap_ge_clk_div", int'((cyc - last_nd) >= CLK_DIV), 1);
      last_nd = cyc;
      seen.push_back(int'($signed(x_out)));
      seen_cyc.push_back(cyc);
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_seen();
    seen.delete();
    seen_cyc.delete();
  endtask

  task automatic collect(int n, string name);
    int budget = 0;
    while (seen.size() < n && budget < 20 * n * CLK_DIV) begin
      step(1);
      budget++;
    end
    if (seen.size() < n) chk({name, "_strobe_timeout"}, seen.size(), n);
  endtask

  task automatic wait_cnt(int v);
    int budget = 0;
    while (m_cnt != v && budget < 4 * CLK_DIV) begin
      step(1);
      budget++;
    end
    if (m_cnt != v) chk("wait_cnt_timeout", m_cnt, v);
  endtask

  function automatic int seen_at(int i);
    return (i < seen.size()) ? seen[i] : 999999;
  endfunction

  function automatic int lat_at(int i, longint ref_cyc);
    return (i < seen_cyc.size()) ? int'(seen_cyc[i] - ref_cyc) : -1;
  endfunction

  task automatic chk_seq(string name, int n, input int e [8]);
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", name, i), seen_at(i), e[i]);
  endtask

  task automatic restart(int sel, logic [31:0] inc, int amp);
    wave_sel  = 2'(sel);
    phase_inc = inc;
    amplitude = 16'(amp);
    enable    = 1'b1;
    phase_clr = 1'b1;
    step(1);
    phase_clr = 1'b0;
    step(3);
    clear_seen();
  endtask

  longint rel_cyc;
  longint clr_cyc;

  initial begin
    for (int i = 0; i < 256; i++) begin
      lut[i] = $rtoi($floor(32767.0 * $sin(3.141592653589793 / 2.0 * real'(i) / 256.0) + 0.5));
    end
    chk("lut0", lut[0], 0);
    chk("lut128", lut[128], 23170);
    chk("lut255", lut[255], 32766);
    chk("model_sine_q1", sample(32'h4000_0000, 0, 32767), 32765);
    chk("model_square_neg", sample(32'h8000_0000, 1, 32767), -32767);
    chk("model_tri_q2", sample(32'hA000_0000, 2, 32767), -16384);
    chk("model_saw_amp_clamp", sample(32'h4000_0000, 3, 65535), 16383);

    step(3);
    chk("reset_new_data", int'(new_data), 0);
    chk("reset_x_out", int'(x_out), 0);

    wave_sel  = 2'd1;
    phase_inc = 32'h4000_0000;
    amplitude = 16'd32767;
    enable    = 1'b1;
    rel_cyc   = cyc;
    rst_n     = 1'b1;
    collect(8, "square");
    chk("square_first_latency", lat_at(0, rel_cyc), 6);
    chk_seq("square", 8, '{32766, 32766, -32767, -32767, 32766, 32766, -32767, -32767});

    restart(2, 32'h2000_0000, 32767);
    collect(8, "tri");
    chk_seq("tri", 8, '{0, 16383, 32766, 16382, 0, -16384, -32767, -16383});

    restart(3, 32'h4000_0000, 16384);
    collect(4, "saw");
    chk_seq("saw", 4, '{0, 8192, -16384, -8192, 0, 0, 0, 0});

    restart(0, 32'h4000_0000, 32767);
    collect(4, "sine");
    chk_seq("sine", 4, '{0, 32765, 0, -32766, 0, 0, 0, 0});

    // Shape switch between ticks: the in-flight sample keeps the old shape.
    wait_cnt(1);
    wave_sel = 2'd1;
    clear_seen();
    collect(2, "midchg");
    chk("midchg_old_shape", int'(seen_at(0) == 32766 || seen_at(0) == -32767), 0);
    chk("midchg_new_shape", int'(seen_at(1) == 32766 || seen_at(1) == -32767), 1);

    // Clear coinciding with a tick: that slot is dropped and the next sample starts at p=0.
    wait_cnt(CLK_DIV - 1);
    wave_sel  = 2'd3;
    phase_clr = 1'b1;
    clr_cyc   = cyc + 1;
    clear_seen();
    step(1);
    phase_clr = 1'b0;
    collect(2, "clr_on_tick");
    chk("clr_on_tick_latency", lat_at(0, clr_cyc), 6);
    chk("clr_on_tick_p0", seen_at(0), 0);
    chk("clr_on_tick_p1", seen_at(1), 16383);

    // Asynchronous reset between clock edges.
    step(1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_new_data", int'(new_data), 0);
    chk("async_reset_x_out", int'(x_out), 0);
    step(2);
    clear_seen();
    rel_cyc = cyc;
    rst_n   = 1'b1;
    collect(2, "post_reset");
    chk("post_reset_latency", lat_at(0, rel_cyc), 6);
    chk("post_reset_p0", seen_at(0), 0);
    chk("post_reset_p1", seen_at(1), 16383);

    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      phase_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) wave_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) amplitude = 16'($urandom);
      if ($urandom_range(0, 29) == 0) phase_inc = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      step(1);
    end
    phase_clr = 1'b0;
    enable    = 1'b0;
    step(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
